// File: rtl/spi_clock_generator_pkg.sv
// Shared constants and helpers for the SPI clock generator.
// Divider ratio and counter widths are derived from the top-level parameters.
package spi_clock_generator_pkg;

    localparam int DEF_CLK_FREQ_HZ  = 100_000_000;
    localparam int DEF_FAST_FREQ_HZ = 10_000_000;
    localparam int DEF_LOCK_DELAY   = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = 1; x < v; x = x << 1)
            r++;
        return r;
    endfunction

    // Counters never shrink below one bit, even for a ratio of 1.
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int div_half(input int clk_hz, input int fast_hz);
        return clk_hz / (2 * fast_hz);
    endfunction

    function automatic int lock_width(input int lock_delay);
        return width_of(lock_delay + 1);
    endfunction

endpackage

// File: rtl/spi_clock_generator_counter.sv
// Generic up-counter with synchronous clear (priority) and enable.
// Wraps naturally from all-ones to zero.
module gu_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            enable,
    output logic [BITS-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (enable)
            count <= count + BITS'(1);
    end

endmodule

// File: rtl/spi_clock_generator.sv
// Counter-based divider producing 10 MHz / 5 MHz clocks, strobes and a
// sticky lock flag once the SPI clock has run for LOCK_DELAY rising edges.
module spi_clock_generator
    import spi_clock_generator_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int FAST_FREQ_HZ = DEF_FAST_FREQ_HZ,
    parameter int LOCK_DELAY   = DEF_LOCK_DELAY
) (
    input  logic clk,
    input  logic reset,
    output logic clk_10MHz,
    output logic clk_5MHz,
    output logic tick_10MHz,
    output logic tick_5MHz,
    output logic locked
);

    localparam int DIV_HALF = div_half(CLK_FREQ_HZ, FAST_FREQ_HZ);
    localparam int DIV_W    = width_of(DIV_HALF);
    localparam int LOCK_W   = lock_width(LOCK_DELAY);

    if (DIV_HALF < 1 || (CLK_FREQ_HZ % (2 * FAST_FREQ_HZ)) != 0
        || LOCK_DELAY < 1) begin : g_bad_params
        $fatal(1, "spi_clock_generator: invalid divider or lock parameters");
    end

    logic [DIV_W-1:0]  div_count;
    logic [LOCK_W-1:0] lock_count;
    logic              wrap;
    logic              rise10;
    logic              rise5;
    logic              lock_en;
    logic              lock_done;

    assign wrap   = (div_count == DIV_W'(DIV_HALF - 1));
    assign rise10 = wrap & ~clk_10MHz;
    assign rise5  = rise10 & ~clk_5MHz;

    // The final rise sets locked on the same edge as the clock outputs.
    assign lock_en   = rise5 & ~locked;
    assign lock_done = lock_en & (lock_count == LOCK_W'(LOCK_DELAY - 1));

    gu_counter #(.BITS(DIV_W)) u_div (
        .clk    (clk),
        .reset  (reset),
        .clr    (wrap),
        .enable (1'b1),
        .count  (div_count)
    );

    gu_counter #(.BITS(LOCK_W)) u_lock (
        .clk    (clk),
        .reset  (reset),
        .clr    (1'b0),
        .enable (lock_en),
        .count  (lock_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_10MHz  <= 1'b0;
            clk_5MHz   <= 1'b0;
            tick_10MHz <= 1'b0;
            tick_5MHz  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            clk_10MHz  <= clk_10MHz ^ wrap;
            tick_10MHz <= rise10;
            tick_5MHz  <= rise5;
            if (rise10)
                clk_5MHz <= ~clk_5MHz;
            if (lock_done)
                locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_clock_generator.sv
// Scoreboard bench: expected strobe/lock edges are queued by the stimulus,
// a negedge monitor pops and compares them against what the DUT shows.
module tb_spi_clock_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_clk10, a_clk5, a_t10, a_t5, a_lk;
    logic       b_clk10, b_clk5, b_t10, b_t5, b_lk;
    logic       gc_clr = 1'b0;
    logic       gc_en = 1'b0;
    logic [2:0] gc_count;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int n;
    bit mon_on = 1'b0;
    bit prev_lk = 1'b0;

    int q10[$];
    int q5[$];
    int qlk[$];
    int qgc[$];

    always #5 clk = ~clk;

    spi_clock_generator u_dut (
        .clk        (clk),
        .reset      (reset),
        .clk_10MHz  (a_clk10),
        .clk_5MHz   (a_clk5),
        .tick_10MHz (a_t10),
        .tick_5MHz  (a_t5),
        .locked     (a_lk)
    );

    spi_clock_generator #(
        .CLK_FREQ_HZ  (40_000_000),
        .FAST_FREQ_HZ (10_000_000),
        .LOCK_DELAY   (1)
    ) u_sweep (
        .clk        (clk),
        .reset      (reset),
        .clk_10MHz  (b_clk10),
        .clk_5MHz   (b_clk5),
        .tick_10MHz (b_t10),
        .tick_5MHz  (b_t5),
        .locked     (b_lk)
    );

    gu_counter #(.BITS(3)) u_gc (
        .clk    (clk),
        .reset  (reset),
        .clr    (gc_clr),
        .enable (gc_en),
        .count  (gc_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    // High from edge 'first' for 'half' edges, then low for 'half', repeating.
    function automatic int sq(input int e, input int first, input int half);
        return (e >= first && ((e - first) / half) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic push_run(input int last);
        q10.delete();
        q5.delete();
        qlk.delete();
        for (int e = 5; e <= last; e += 10)
            q10.push_back(e);
        for (int e = 5; e <= last; e += 20)
            q5.push_back(e);
        if (last >= 65)
            qlk.push_back(65);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset)
            edge_n = 0;
        else
            edge_n = edge_n + 1;
    end

    always @(negedge clk) begin
        n = edge_n;
        if (reset && mon_on) begin
            check("clk10_level", a_clk10, sq(n, 5, 5));
            check("clk5_level", a_clk5, sq(n, 5, 10));
            check("locked_level", a_lk, (n >= 65) ? 1 : 0);
            if (a_t10) begin
                if (q10.size() == 0) check("tick10_extra", n, -1);
                else check("tick10_edge", n, q10.pop_front());
            end
            if (a_t5) begin
                if (q5.size() == 0) check("tick5_extra", n, -1);
                else check("tick5_edge", n, q5.pop_front());
            end
            if (a_lk && !prev_lk) begin
                if (qlk.size() == 0) check("lock_extra", n, -1);
                else check("lock_edge", n, qlk.pop_front());
            end
            check("sw_clk10", b_clk10, sq(n, 2, 2));
            check("sw_clk5", b_clk5, sq(n, 2, 4));
            check("sw_tick10", b_t10, (n >= 2 && (n - 2) % 4 == 0) ? 1 : 0);
            check("sw_tick5", b_t5, (n >= 2 && (n - 2) % 8 == 0) ? 1 : 0);
            check("sw_locked", b_lk, (n >= 2) ? 1 : 0);
        end
        if (reset && qgc.size() > 0)
            check("gu_count", gc_count, qgc.pop_front());
        prev_lk = a_lk;
    end

    localparam int GN = 15;
    bit gen_t[GN] = '{1,1,1,1,1,1,1,1,1,1,0,0,1,1,0};
    bit gcl_t[GN] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0,1};
    int gex_t[GN] = '{1,2,3,4,5,6,7,0,1,2,2,2,0,1,0};

    initial begin
        #2;
        check("rst_clk10", a_clk10, 0);
        check("rst_clk5", a_clk5, 0);
        check("rst_tick10", a_t10, 0);
        check("rst_tick5", a_t5, 0);
        check("rst_locked", a_lk, 0);
        check("rst_sw_locked", b_lk, 0);
        check("rst_gu", gc_count, 0);

        @(negedge clk);
        push_run(1000);
        mon_on = 1'b1;
        reset = 1'b1;
        while (edge_n < 1000) @(negedge clk);
        check("locked_at_1000", a_lk, 1);
        check("q10_left", q10.size(), 0);
        check("q5_left", q5.size(), 0);
        check("qlk_left", qlk.size(), 0);

        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_run(37);
        reset = 1'b1;
        while (edge_n < 37) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_clk10", a_clk10, 0);
        check("async_clk5", a_clk5, 0);
        check("async_tick10", a_t10, 0);
        check("async_tick5", a_t5, 0);
        check("async_locked", a_lk, 0);
        check("async_sw_locked", b_lk, 0);
        check("async_sw_clk5", b_clk5, 0);
        check("q10_pre_reset", q10.size(), 0);
        check("q5_pre_reset", q5.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_run(100);
        reset = 1'b1;
        while (edge_n < 100) @(negedge clk);
        check("q10_after_rst", q10.size(), 0);
        check("q5_after_rst", q5.size(), 0);
        check("qlk_after_rst", qlk.size(), 0);
        mon_on = 1'b0;

        for (int i = 0; i < GN; i++) begin
            @(negedge clk);
            gc_en  = gen_t[i];
            gc_clr = gcl_t[i];
            @(posedge clk);
            qgc.push_back(gex_t[i]);
        end
        @(negedge clk);
        gc_en  = 1'b0;
        gc_clr = 1'b0;
        @(negedge clk);
        check("qgc_left", qgc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
